// File: rtl/gpu_mem_pkg.sv
// Shared constants and types for the GPU data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_mem_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 18;
   localparam int LANES     = 3;
   localparam int MEM_WORDS = 1 << ADDR_W;

   typedef logic [LANES-1:0][DATA_W-1:0] lane_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DUMP = 2'd2,
      CSUM = 2'd3
   } mem_state_t;

endpackage

// File: rtl/gpu_mem_array.sv
// Storage array: LANES combinational read ports, one host read port, lane-priority write.
// Latency: reads are zero-cycle; writes land on the next CLK edge (read-during-write sees old data).
// Backpressure: none; the caller gates gpuWe/hostWe.
module gpu_mem_array
   import gpu_mem_pkg::*;
(
   input  logic                           CLK,
   input  logic [LANES-1:0][ADDR_W-1:0]   laneAddr,
   output logic [LANES-1:0][DATA_W-1:0]   laneRdData,
   input  logic                           gpuWe,
   input  logic [LANES-1:0][DATA_W-1:0]   laneWrData,
   input  logic [ADDR_W-1:0]              hostAddr,
   output logic [DATA_W-1:0]              hostRdData,
   input  logic                           hostWe,
   input  logic [DATA_W-1:0]              hostWrData
);

   logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

   // Combinational reads for every GPU lane and for the host dump path.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         laneRdData[i] = mem[laneAddr[i]];
      end
      hostRdData = mem[hostAddr];
   end

   // Writes; lanes are applied in ascending order so the highest lane wins a collision.
   always_ff @(posedge CLK) begin
      if (gpuWe) begin
         for (int i = 0; i < LANES; i++) begin
            mem[laneAddr[i]] <= laneWrData[i];
         end
      end
      if (hostWe) begin
         mem[hostAddr] <= hostWrData;
      end
   end

endmodule

// File: rtl/gpu_data_mem.sv
// GPU three-lane data memory with host LOAD/DUMP engine; GPU stalled via gpu_hold while host owns it.
// Latency: GPU reads zero-cycle, writes one edge; done pulses the cycle after the final accepted beat.
// Backpressure: LOAD waits on in_valid; DUMP holds out_valid/out_data until out_ready.
// Optional: define GPU_MEM_DUMP_CHECKSUM_EN to append an 18-bit running-sum beat after the DUMP data.
module gpu_data_mem
   import gpu_mem_pkg::*;
#(
   parameter int IMG_WORDS = 1024
)
(
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [ADDR_W-1:0]              A1,
   input  logic [ADDR_W-1:0]              A2,
   input  logic [ADDR_W-1:0]              A3,
   input  logic                           MemWrite,
   input  logic [LANES-1:0][DATA_W-1:0]   writeData,
   output logic [LANES-1:0][DATA_W-1:0]   ReadData,
   output logic                           gpu_hold,
   input  logic                           host_load,
   input  logic                           host_dump,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           done
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMG_WORDS - 1);

   mem_state_t                   state;
   logic [ADDR_W:0]              cnt;
   logic [LANES-1:0][ADDR_W-1:0] laneAddr;
   logic [DATA_W-1:0]            hostRdData;
   logic                         gpuWe;
   logic                         hostWe;
   logic                         lastIdx;
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0]            csum;
`endif

   assign laneAddr = {A3, A2, A1};
   assign gpuWe    = MemWrite && (state == IDLE);
   assign hostWe   = (state == LOAD) && in_valid && in_ready;
   assign lastIdx  = (cnt == LAST_IDX);

   gpu_mem_array u_array (
      .CLK        (CLK),
      .laneAddr   (laneAddr),
      .laneRdData (ReadData),
      .gpuWe      (gpuWe),
      .laneWrData (writeData),
      .hostAddr   (cnt[ADDR_W-1:0]),
      .hostRdData (hostRdData),
      .hostWe     (hostWe),
      .hostWrData (in_data)
   );

   // Dump data path: array word at cnt while dumping, checksum in CSUM, zero otherwise.
   always_comb begin
      out_data = '0;
      case (state)
         DUMP:    out_data = hostRdData;
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
         CSUM:    out_data = csum;
`endif
         default: out_data = '0;
      endcase
   end

   // Transfer FSM with registered handshake, hold and done outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         gpu_hold  <= 1'b0;
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (host_load) begin
                  state    <= LOAD;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  gpu_hold <= 1'b1;
               end else if (host_dump) begin
                  state     <= DUMP;
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  gpu_hold  <= 1'b1;
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end
            LOAD: begin
               if (in_valid && in_ready) begin
                  cnt <= cnt + (ADDR_W+1)'(1);
                  if (lastIdx) begin
                     state    <= IDLE;
                     in_ready <= 1'b0;
                     gpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            DUMP: begin
               if (out_valid && out_ready) begin
                  cnt <= cnt + (ADDR_W+1)'(1);
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
                  csum <= csum + out_data;
                  if (lastIdx) begin
                     state <= CSUM;
                  end
`else
                  if (lastIdx) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     gpu_hold  <= 1'b0;
                     done      <= 1'b1;
                  end
`endif
               end
            end
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
            CSUM: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  gpu_hold  <= 1'b0;
                  done      <= 1'b1;
               end
            end
`endif
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               gpu_hold  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_data_mem.sv
// Self-checking bench for gpu_data_mem with a four-word image.
// Latency: n/a (testbench).
// Backpressure: drives in_valid toggling and out_ready stalls.
module tb_gpu_data_mem;
   import gpu_mem_pkg::*;

   localparam int IMG = 4;

   logic                         CLK = 1'b0;
   logic                         RST;
   logic [ADDR_W-1:0]            A1, A2, A3;
   logic                         MemWrite;
   lane_data_t                   writeData;
   lane_data_t                   ReadData;
   logic                         gpu_hold;
   logic                         host_load, host_dump;
   logic [DATA_W-1:0]            in_data;
   logic                         in_valid, in_ready;
   logic [DATA_W-1:0]            out_data;
   logic                         out_valid, out_ready;
   logic                         done;

   always #5 CLK = ~CLK;

   gpu_data_mem #(.IMG_WORDS(IMG)) dut (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
      .MemWrite(MemWrite), .writeData(writeData), .ReadData(ReadData),
      .gpu_hold(gpu_hold), .host_load(host_load), .host_dump(host_dump),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .done(done)
   );

   // Reference memory: plain array, lanes applied in order so later lanes overwrite.
   logic [DATA_W-1:0] model_mem [0:MEM_WORDS-1];
   logic [DATA_W-1:0] loadWords [0:IMG-1];
   int nChecks = 0;
   int nPass   = 0;

   typedef struct {
      logic [ADDR_W-1:0] a1, a2, a3;
      lane_data_t        wd;
      lane_data_t        expRd;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   function automatic lane_data_t model_read(input logic [ADDR_W-1:0] a1, a2, a3);
      lane_data_t r;
      r[0] = model_mem[a1];
      r[1] = model_mem[a2];
      r[2] = model_mem[a3];
      return r;
   endfunction

   task automatic model_write(input logic [ADDR_W-1:0] a1, a2, a3, input lane_data_t wd);
      model_mem[a1] = wd[0];
      model_mem[a2] = wd[1];
      model_mem[a3] = wd[2];
   endtask

   task automatic check_mem(input string name, input int addr);
      MemWrite = 1'b0;
      A1 = ADDR_W'(addr);
      #1;
      check(name, 64'(ReadData[0]), 64'(model_mem[addr]));
   endtask

   // Host LOAD of loadWords; abortAt >= 0 asserts RST after that many accepted beats.
   task automatic run_load(input int abortAt);
      int beats = 0;
      int cyc = 0;
      logic acc;
      host_load = 1'b1;
      host_dump = 1'b1;
      step;
      host_load = 1'b0;
      host_dump = 1'b0;
      check("load_hold", 64'(gpu_hold), 64'd1);
      check("load_prio_ready", 64'(in_ready), 64'd1);
      check("load_prio_nodump", 64'(out_valid), 64'd0);
      MemWrite = 1'b1;
      A1 = 10'd100; A2 = 10'd101; A3 = 10'd102;
      writeData = {18'h3FFFF, 18'h3FFFF, 18'h3FFFF};
      while (beats < IMG && cyc < 100) begin
         in_valid  = (cyc % 2 == 0) || ($urandom_range(0, 1) == 1);
         in_data   = loadWords[beats];
         host_dump = (cyc == 3);
         check("load_hold_cyc", 64'(gpu_hold), 64'd1);
         acc = in_valid && in_ready;
         step;
         host_dump = 1'b0;
         if (acc) begin
            model_mem[beats] = loadWords[beats];
            beats++;
         end
         cyc++;
         if (abortAt >= 0 && beats == abortAt) begin
            in_valid = 1'b0;
            MemWrite = 1'b0;
            RST = 1'b1;
            step;
            RST = 1'b0;
            check("load_rst_hold", 64'(gpu_hold), 64'd0);
            check("load_rst_ready", 64'(in_ready), 64'd0);
            check("load_rst_done", 64'(done), 64'd0);
            return;
         end
      end
      in_valid = 1'b0;
      MemWrite = 1'b0;
      if (cyc >= 100) check("load_timeout", 64'(beats), 64'(IMG));
      check("load_done", 64'(done), 64'd1);
      check("load_end_hold", 64'(gpu_hold), 64'd0);
      check("load_end_ready", 64'(in_ready), 64'd0);
      step;
      check("load_done_pulse", 64'(done), 64'd0);
   endtask

   // Host DUMP; stalls beat stallBeat for 3 cycles, abortAt >= 0 asserts RST at that beat.
   task automatic run_dump(input int stallBeat, input int abortAt);
      logic [DATA_W-1:0] exp [$];
      logic [DATA_W-1:0] sum = '0;
      int idx = 0;
      int cyc = 0;
      int stall = 0;
      for (int i = 0; i < IMG; i++) begin
         exp.push_back(model_mem[i]);
         sum = sum + model_mem[i];
      end
`ifdef GPU_MEM_DUMP_CHECKSUM_EN
      exp.push_back(sum);
`endif
      host_dump = 1'b1;
      step;
      host_dump = 1'b0;
      check("dump_hold", 64'(gpu_hold), 64'd1);
      check("dump_noready", 64'(in_ready), 64'd0);
      MemWrite = 1'b1;
      A1 = 10'd200; A2 = 10'd200; A3 = 10'd200;
      writeData = {18'h15555, 18'h15555, 18'h15555};
      while (idx < exp.size() && cyc < 100) begin
         if (idx == abortAt) begin
            out_ready = 1'b0;
            MemWrite  = 1'b0;
            RST = 1'b1;
            step;
            RST = 1'b0;
            check("dump_rst_valid", 64'(out_valid), 64'd0);
            check("dump_rst_hold", 64'(gpu_hold), 64'd0);
            check("dump_rst_done", 64'(done), 64'd0);
            check("dump_rst_data", 64'(out_data), 64'd0);
            return;
         end
         out_ready = !(idx == stallBeat && stall < 3);
         check("dump_valid", 64'(out_valid), 64'd1);
         check("dump_data", 64'(out_data), 64'(exp[idx]));
         if (!out_ready) stall++;
         step;
         if (out_ready) idx++;
         cyc++;
      end
      out_ready = 1'b0;
      MemWrite  = 1'b0;
      if (cyc >= 100) check("dump_timeout", 64'(idx), 64'(exp.size()));
      check("dump_done", 64'(done), 64'd1);
      check("dump_end_valid", 64'(out_valid), 64'd0);
      check("dump_end_hold", 64'(gpu_hold), 64'd0);
      step;
      check("dump_done_pulse", 64'(done), 64'd0);
      check_mem("dump_memwrite_ignored", 200);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      lane_data_t wd;
      logic [ADDR_W-1:0] a1, a2, a3;

      RST = 1'b1; A1 = '0; A2 = '0; A3 = '0; MemWrite = 1'b0; writeData = '0;
      host_load = 1'b0; host_dump = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      step;
      step;
      check("rst_hold", 64'(gpu_hold), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      RST = 1'b0;
      step;

      // Fill the whole array with known values through the GPU port.
      MemWrite = 1'b1;
      for (int a = 0; a < MEM_WORDS; a += 3) begin
         a1 = ADDR_W'(a); a2 = ADDR_W'(a + 1); a3 = ADDR_W'(a + 2);
         for (int l = 0; l < LANES; l++) wd[l] = DATA_W'($urandom);
         A1 = a1; A2 = a2; A3 = a3; writeData = wd;
         step;
         model_write(a1, a2, a3, wd);
      end
      MemWrite = 1'b0;

      // Directed GPU write vectors with constant expected read-back.
      vecs[0] = '{a1: 10'd5,    a2: 10'd6,  a3: 10'd7,   wd: {18'h2AAAA, 18'h00001, 18'h3FFFF}, expRd: {18'h2AAAA, 18'h00001, 18'h3FFFF}};
      vecs[1] = '{a1: 10'd10,   a2: 10'd10, a3: 10'd10,  wd: {18'd3, 18'd2, 18'd1},             expRd: {18'd3, 18'd3, 18'd3}};
      vecs[2] = '{a1: 10'd20,   a2: 10'd21, a3: 10'd20,  wd: {18'd7, 18'd6, 18'd5},             expRd: {18'd7, 18'd6, 18'd7}};
      vecs[3] = '{a1: 10'd1023, a2: 10'd0,  a3: 10'd512, wd: {18'h12345, 18'h00000, 18'h3FFFF}, expRd: {18'h12345, 18'h00000, 18'h3FFFF}};
      vecs[4] = '{a1: 10'd10,   a2: 10'd5,  a3: 10'd6,   wd: {18'd9, 18'd8, 18'd4},             expRd: {18'd9, 18'd8, 18'd4}};
      for (int i = 0; i < 5; i++) begin
         A1 = vecs[i].a1; A2 = vecs[i].a2; A3 = vecs[i].a3;
         writeData = vecs[i].wd; MemWrite = 1'b1;
         #2;
         check("vec_old_data", 64'(ReadData), 64'(model_read(vecs[i].a1, vecs[i].a2, vecs[i].a3)));
         step;
         MemWrite = 1'b0;
         model_write(vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].wd);
         #1;
         check("vec_new_data", 64'(ReadData), 64'(vecs[i].expRd));
      end

      // Random GPU traffic against the reference array.
      for (int c = 0; c < 300; c++) begin
         a1 = ADDR_W'($urandom);
         a2 = ($urandom_range(0, 3) == 0) ? a1 : ADDR_W'($urandom);
         a3 = ($urandom_range(0, 3) == 0) ? a2 : ADDR_W'($urandom);
         for (int l = 0; l < LANES; l++) wd[l] = DATA_W'($urandom);
         A1 = a1; A2 = a2; A3 = a3; writeData = wd;
         MemWrite = ($urandom_range(0, 1) == 1);
         #1;
         check("rand_read", 64'(ReadData), 64'(model_read(a1, a2, a3)));
         step;
         if (MemWrite) model_write(a1, a2, a3, wd);
      end
      MemWrite = 1'b0;

      // LOAD 11,22,33,44 then DUMP with a stall on beat 1.
      loadWords[0] = 18'd11; loadWords[1] = 18'd22; loadWords[2] = 18'd33; loadWords[3] = 18'd44;
      run_load(-1);
      for (int i = 0; i < IMG; i++) check_mem("load_readback", i);
      check_mem("load_memwrite_ignored", 100);
      check_mem("load_memwrite_ignored", 102);
      run_dump(1, -1);

      // Reset mid-DUMP at beat 2, then a fresh DUMP restarts at word 0.
      run_dump(-1, 2);
      run_dump(-1, -1);

      // Reset mid-LOAD keeps the words already written.
      for (int i = 0; i < IMG; i++) loadWords[i] = DATA_W'($urandom);
      run_load(2);
      for (int i = 0; i < IMG; i++) check_mem("partial_load_kept", i);

      // Random full LOAD/DUMP round trip.
      for (int i = 0; i < IMG; i++) loadWords[i] = DATA_W'($urandom);
      run_load(-1);
      run_dump(0, -1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/gpu_data_mem.md
Name: gpu_data_mem

Overview:
- Data-memory responder for the filter GPU's three-lane load/store port.
- Serves three independent 10-bit addresses (A1..A3) with 18-bit lanes, combinational read, synchronous write on MemWrite.
- Host-side LOAD/DUMP engine moves an image into and out of the array over valid/ready streams.
- Asserts gpu_hold so the GPU stalls while the host owns the array.

Parameters:
- ADDR_W, 10, address width per lane
- DATA_W, 18, lane data width
- LANES, 3, number of GPU lanes
- IMG_WORDS, 1024, words moved per LOAD/DUMP; range 1..2^ADDR_W

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- A1, A2, A3  in  ADDR_W each  lane 0/1/2 addresses from the GPU
- MemWrite  in  1  GPU store strobe
- writeData  in  [LANES-1:0][DATA_W-1:0]  store data per lane
- ReadData  out  [LANES-1:0][DATA_W-1:0]  load data per lane
- gpu_hold  out  1  GPU must stall; high in LOAD and DUMP
- host_load  in  1  start-LOAD pulse
- host_dump  in  1  start-DUMP pulse
- in_data  in  DATA_W  host write stream data
- in_valid  in  1  host write stream valid
- in_ready  out  1  host write stream ready
- out_data  out  DATA_W  dump stream data
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- done  out  1  one-cycle pulse when LOAD or DUMP completes

Behaviour:
- Storage: 2^ADDR_W x DATA_W register array. Contents are not cleared by RST.
- GPU read: ReadData[i] = mem[A(i+1)], combinational, zero latency.
- GPU write (IDLE only): on the CLK edge with MemWrite=1, mem[A(i+1)] <= writeData[i] for all lanes.
  - Same-address collision: the highest lane index wins (lane 2 > 1 > 0).
  - Read-during-write returns old data in that cycle.
- In LOAD or DUMP, MemWrite is ignored. ReadData still reflects the array.
- FSM states: IDLE, LOAD, DUMP (plus CSUM when the optional feature is on).
- IDLE:
  - host_load=1 -> LOAD; host_load has priority over host_dump.
  - host_dump=1 -> DUMP.
  - The address counter cnt is cleared on entry to either state.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes mem[cnt] <= in_data, then cnt++.
  - On the beat where cnt==IMG_WORDS-1: done=1 next cycle, return to IDLE.
- DUMP:
  - out_data=mem[cnt], out_valid=1.
  - Each out_valid&out_ready beat increments cnt.
  - out_data must stay stable while out_valid&!out_ready.
  - Last beat (cnt==IMG_WORDS-1 accepted) -> IDLE with a done pulse.
- gpu_hold = (state!=IDLE). It is asserted the cycle after the start pulse is sampled.
- Start pulses arriving in LOAD or DUMP are ignored.
- cnt is ADDR_W+1 bits wide, so IMG_WORDS = 2^ADDR_W does not wrap early.
- RST mid-transfer: next cycle state=IDLE, cnt=0, and in_ready, out_valid, done, gpu_hold are all 0. Partially loaded data is kept.
- Reset values: in_ready=0, out_valid=0, out_data=0, done=0, gpu_hold=0.

Optional Feature:
- Macro: GPU_MEM_DUMP_CHECKSUM_EN
- Defined:
  - An 18-bit running sum (mod 2^18) accumulates every accepted DUMP word.
  - After the last data beat, FSM enters CSUM and presents the sum as one extra beat (out_valid=1, held until out_ready).
  - done pulses after the checksum beat is accepted.
  - The sum clears on DUMP entry and on RST.
- Undefined: no CSUM state; DUMP ends at the last data word.

Decomposition:
- Package gpu_mem_pkg holds:
  - ADDR_W, DATA_W, LANES constants
  - lane_data_t = logic [LANES-1:0][DATA_W-1:0]
  - enum mem_state_t {IDLE, LOAD, DUMP, CSUM}
- One sub-module: gpu_mem_array, the storage array with LANES combinational read ports and a priority-resolved write port (GPU lanes or host LOAD mux).
- FSM and counters stay in gpu_data_mem.

Test Plan:
- Reset then IDLE -> gpu_hold=0, in_ready=0, out_valid=0, done=0.
- IDLE, MemWrite=1, A1=5/A2=6/A3=7, writeData={3'h?: 18'h3FFFF, 18'h00001, 18'h2AAAA} -> next cycle ReadData for those addresses returns the written lane values.
- Collision: A1=A2=A3=10, data 1/2/3 -> mem[10]=3. Same cycle ReadData shows old value.
- host_load with IMG_WORDS=4, words 11,22,33,44, in_valid toggling -> gpu_hold=1 throughout, done after 4th beat, mem[0..3]=11,22,33,44.
- host_dump with out_ready stalled 3 cycles on beat 1 -> out_data holds 22 while stalled. Sequence is 11,22,33,44. With the checksum macro, a 5th beat = 110 precedes done.
- RST asserted mid-DUMP at beat 2 -> next cycle IDLE, out_valid=0. A subsequent host_dump restarts at word 0.
